// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

  localparam int STAT_WIDTH = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    logic [STAT_WIDTH-1:0] r;
    if (v == {STAT_WIDTH{1'b1}}) begin
      r = v;
    end else begin
      r = v + STAT_WIDTH'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_arbiter_2p_rr_arb2.sv
// Two-input round-robin picker: combinational grant, registered last winner.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t rr_last_r;
  logic    gnt_a_s;
  logic    gnt_b_s;

  // Pick a winner; on a tie the requester that did not win last goes first.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if (rr_last_r == REQ_B) begin
          gnt_a_s = 1'b1;
        end else begin
          gnt_b_s = 1'b1;
        end
      end else begin
        gnt_a_s = req_a;
        gnt_b_s = req_b;
      end
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // Remember the most recent winner; idle cycles leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_r <= REQ_B;
    end else if (gnt_a_s) begin
      rr_last_r <= REQ_A;
    end else if (gnt_b_s) begin
      rr_last_r <= REQ_B;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  assign gnt_a = gnt_a_s;
  assign gnt_b = gnt_b_s;

endmodule

// File: rtl/sram_arbiter_2p.sv
// Shares one single-port SRAM between requesters A and B after a zero-fill pass.
// Optional grant/conflict counters are enabled with `define SRAM_ARB_STATS_EN.
module sram_arbiter_2p
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  init_done
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] a_gnt_cnt,
  output logic [STAT_WIDTH-1:0] b_gnt_cnt,
  output logic [STAT_WIDTH-1:0] conflict_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   init_cnt_r, init_cnt_nxt_s;
  logic                    init_done_r, init_done_nxt_s;
  logic                    rd_pend_r, rd_pend_nxt_s;
  req_id_t                 rd_owner_r, rd_owner_nxt_s;
  logic [ADDR_WIDTH-1:0]   last_addr_r;
  logic                    gnt_a_s, gnt_b_s;
  logic                    mem_wr_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_din_s;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (state_r == RUN),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (gnt_a_s),
    .gnt_b (gnt_b_s)
  );

  // Next state and SRAM drive; an idle cycle reads the held address and drops it.
  always_comb begin
    state_nxt_s     = state_r;
    init_cnt_nxt_s  = init_cnt_r;
    init_done_nxt_s = init_done_r;
    rd_pend_nxt_s   = 1'b0;
    rd_owner_nxt_s  = rd_owner_r;
    mem_wr_s        = 1'b0;
    mem_addr_s      = last_addr_r;
    mem_din_s       = '0;
    case (state_r)
      INIT: begin
        mem_wr_s   = 1'b1;
        mem_addr_s = init_cnt_r;
        if (init_cnt_r == LAST_ADDR) begin
          state_nxt_s     = RUN;
          init_done_nxt_s = 1'b1;
          init_cnt_nxt_s  = '0;
        end else begin
          init_cnt_nxt_s  = init_cnt_r + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (gnt_a_s) begin
          mem_wr_s       = a_wr;
          mem_addr_s     = a_addr;
          mem_din_s      = a_din;
          rd_pend_nxt_s  = ~a_wr;
          rd_owner_nxt_s = REQ_A;
        end else if (gnt_b_s) begin
          mem_wr_s       = b_wr;
          mem_addr_s     = b_addr;
          mem_din_s      = b_din;
          rd_pend_nxt_s  = ~b_wr;
          rd_owner_nxt_s = REQ_B;
        end else begin
          mem_wr_s       = 1'b0;
        end
      end
      default: begin
        state_nxt_s = INIT;
      end
    endcase
  end

  // Control state, init counter and the one-deep read-return pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= INIT;
      init_cnt_r  <= '0;
      init_done_r <= 1'b0;
      rd_pend_r   <= 1'b0;
      rd_owner_r  <= REQ_A;
      last_addr_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      init_cnt_r  <= init_cnt_nxt_s;
      init_done_r <= init_done_nxt_s;
      rd_pend_r   <= rd_pend_nxt_s;
      rd_owner_r  <= rd_owner_nxt_s;
      last_addr_r <= mem_addr_s;
    end
  end

  assign a_gnt     = gnt_a_s;
  assign b_gnt     = gnt_b_s;
  assign a_rvalid  = rd_pend_r && (rd_owner_r == REQ_A);
  assign b_rvalid  = rd_pend_r && (rd_owner_r == REQ_B);
  assign a_rdata   = a_rvalid ? mem_dout : '0;
  assign b_rdata   = b_rvalid ? mem_dout : '0;
  assign mem_wr    = mem_wr_s;
  assign mem_addr  = mem_addr_s;
  assign mem_din   = mem_din_s;
  assign init_done = init_done_r;

`ifdef SRAM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] a_cnt_r, b_cnt_r, conf_cnt_r;

  // Saturating grant and contention counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_cnt_r    <= '0;
      b_cnt_r    <= '0;
      conf_cnt_r <= '0;
    end else begin
      a_cnt_r    <= gnt_a_s ? sat_inc(a_cnt_r) : a_cnt_r;
      b_cnt_r    <= gnt_b_s ? sat_inc(b_cnt_r) : b_cnt_r;
      conf_cnt_r <= (state_r == RUN && a_req && b_req) ? sat_inc(conf_cnt_r) : conf_cnt_r;
    end
  end

  assign a_gnt_cnt    = a_cnt_r;
  assign b_gnt_cnt    = b_cnt_r;
  assign conflict_cnt = conf_cnt_r;
`endif

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Scoreboard bench for sram_arbiter_2p with a behavioural SRAM and reference model.
module tb_sram_arbiter_2p;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, mem_wr, init_done;
  logic [DW-1:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] a_gnt_cnt, b_gnt_cnt, conflict_cnt;
`endif

  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  exp_t exp_q[$];
  exp_t mon_e;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int init_left = 0;
  int last_win = 1;
  int m_a = 0, m_b = 0, m_conf = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wr) sram[mem_addr] <= mem_din;
    else        mem_dout <= sram[mem_addr];
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] <= DW'($urandom_range(1, 15));
  end

  sram_arbiter_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .init_done(init_done)
`ifdef SRAM_ARB_STATS_EN
    , .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (a_rvalid || b_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rvalid: got a=%0b b=%0b, expected none (cycle %0d)", a_rvalid, b_rvalid, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rv_cycle", cyc, mon_e.due);
        chk("rv_both", {31'd0, a_rvalid && b_rvalid}, 32'd0);
        chk("rv_owner", {31'd0, b_rvalid}, {31'd0, mon_e.owner});
        chk("rdata", mon_e.owner ? b_rdata : a_rdata, mon_e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_rvalid: got none, expected owner %0d data %0h due %0d", mon_e.owner, mon_e.data, mon_e.due);
    end
    if (!a_rvalid) chk("a_rdata_zero", a_rdata, 0);
    if (!b_rvalid) chk("b_rdata_zero", b_rdata, 0);
  end

  // One cycle: check the DUT against the model at negedge, retire granted requests.
  task automatic step();
    bit ga, gb, wr;
    int addr, din;
    ga = 0; gb = 0;
    @(negedge clk);
    if (init_left > 0) begin
      chk("init_wr", mem_wr, 1);
      chk("init_addr", mem_addr, DEPTH - init_left);
      chk("init_din", mem_din, 0);
      chk("init_gnt", {a_gnt, b_gnt}, 0);
      chk("init_done_lo", init_done, 0);
      ref_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      chk("init_done_hi", init_done, 1);
      ga = a_req && (!b_req || last_win == 1);
      gb = b_req && !ga;
      chk("a_gnt", a_gnt, ga);
      chk("b_gnt", b_gnt, gb);
      if (a_req && b_req) m_conf++;
      if (ga || gb) begin
        wr   = gb ? b_wr : a_wr;
        addr = gb ? b_addr : a_addr;
        din  = gb ? b_din : a_din;
        chk("mem_wr", mem_wr, wr);
        chk("mem_addr", mem_addr, addr);
        if (wr) begin
          chk("mem_din", mem_din, din);
          ref_mem[addr] = DW'(din);
        end else begin
          exp_t e;
          e.owner = gb;
          e.data  = ref_mem[addr];
          e.due   = cyc + 1;
          exp_q.push_back(e);
        end
        last_win = gb ? 1 : 0;
        if (gb) m_b++; else m_a++;
      end else begin
        chk("mem_wr_idle", mem_wr, 0);
      end
    end
    @(posedge clk);
    #1;
    if (ga) a_req = 1'b0;
    if (gb) b_req = 1'b0;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && (a_req || b_req); k++) step();
    chk("req_timeout", {31'd0, a_req || b_req}, 0);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    last_win = 1; init_left = DEPTH;
    m_a = 0; m_b = 0; m_conf = 0;
    @(negedge clk);
    chk("rst_gnt", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 0);
    chk("rst_init_done", init_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_a(input bit w, input int addr, input int d);
    a_req = 1'b1; a_wr = w; a_addr = AW'(addr); a_din = DW'(d);
  endtask

  task automatic set_b(input bit w, input int addr, input int d);
    b_req = 1'b1; b_wr = w; b_addr = AW'(addr); b_din = DW'(d);
  endtask

  task automatic stats_check();
`ifdef SRAM_ARB_STATS_EN
    chk("a_gnt_cnt", a_gnt_cnt, m_a);
    chk("b_gnt_cnt", b_gnt_cnt, m_b);
    chk("conflict_cnt", conflict_cnt, m_conf);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Zero-fill with A requesting throughout INIT; A is served only afterwards.
    do_reset();
    set_a(1'b0, 7, 0);
    repeat (DEPTH) step();
    wait_done();
    idle(2);

    // Write then read back the same address.
    set_a(1'b1, 3, 4'hA);
    wait_done();
    set_a(1'b0, 3, 0);
    wait_done();
    idle(2);

    // Both requesters reading continuously: grants alternate, counters track.
    do_reset();
    repeat (DEPTH) step();
    for (int i = 0; i < 4; i++) begin
      set_a(1'b0, 1, 0);
      set_b(1'b0, 2, 0);
      step();
    end
    idle(2);
    stats_check();

    // Untouched address must read back the zero fill.
    set_a(1'b0, 5, 0);
    wait_done();
    idle(2);

    // Randomised traffic from both sides.
    for (int i = 0; i < 400; i++) begin
      if (!a_req && $urandom_range(0, 2) == 0) set_a(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
      else if (a_req && $urandom_range(0, 15) == 0) a_req = 1'b0;
      if (!b_req && $urandom_range(0, 2) == 0) set_b(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
      else if (b_req && $urandom_range(0, 15) == 0) b_req = 1'b0;
      step();
    end
    idle(3);
    stats_check();

    // Reset right after a B read grant: the read return is dropped, INIT restarts.
    set_b(1'b0, 9, 0);
    wait_done();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_b_rvalid", b_rvalid, 0);
    chk("mid_rst_b_rdata", b_rdata, 0);
    do_reset();
    set_a(1'b0, 9, 0);
    repeat (DEPTH) step();
    wait_done();
    idle(3);
    stats_check();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_2p.md
Name: sram_arbiter_2p

Overview:
- Shares one single-port SRAM (ADDR_WIDTH/DATA_WIDTH/DEPTH, registered 1-cycle read, write-or-read each cycle) between two requesters, A and B.
- After reset, a sequencer zero-fills every SRAM word before any requester is served.
- In service, round-robin arbitration grants one access per cycle and routes read data back to the owner with a valid strobe.
- Sits between the SRAM instance and two client blocks. The SRAM's own rst input is tied high outside this block.

Parameters:
- ADDR_WIDTH, 4, SRAM address width.
- DATA_WIDTH, 4, SRAM word width.
- DEPTH, 16, number of words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A wants an access this cycle.
- a_wr  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  access address.
- a_din  in  DATA_WIDTH  write data.
- a_gnt  out  1  A's access is issued this cycle (combinational).
- a_rvalid  out  1  a_rdata is valid this cycle.
- a_rdata  out  DATA_WIDTH  read data for A.
- b_req, b_wr, b_addr, b_din, b_gnt, b_rvalid, b_rdata: same as the a_* ports, for requester B.
- mem_wr  out  1  to SRAM wr.
- mem_addr  out  ADDR_WIDTH  to SRAM addr.
- mem_din  out  DATA_WIDTH  to SRAM din.
- mem_dout  in  DATA_WIDTH  from SRAM dout.
- init_done  out  1  high once zero-fill is complete.

Behaviour:
- Reset (rst=0, async): state=INIT, init_cnt=0, rr_last=B (so A wins the first tie), rd_pend=0, rd_owner=A, init_done=0.
  - All gnt/rvalid are 0 during reset and in INIT.
  - a_rdata/b_rdata are 0 whenever their rvalid is 0.
- FSM state INIT:
  - Drives mem_wr=1, mem_addr=init_cnt, mem_din=0.
  - init_cnt increments each cycle.
  - The cycle that writes DEPTH-1 moves the FSM to RUN on the next edge and sets init_done=1.
  - INIT lasts exactly DEPTH cycles. Requests are ignored, not queued, and gnt stays 0.
- FSM state RUN, one grant per cycle:
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the requester other than rr_last.
  - rr_last updates to the granted requester on the edge. It is unchanged when there is no grant.
- Grant cycle drives the winner's wr/addr/din onto mem_*. The SRAM samples at that edge.
- Writes: complete at the grant edge; no response strobe.
- Reads: rd_pend=1 and rd_owner=winner are registered at the grant edge. In the next cycle, the owner's rvalid=1 and its rdata=mem_dout.
  - Read latency is therefore 1 cycle after the grant cycle.
  - Back-to-back reads from alternating owners pipeline at full rate.
- No grant: mem_wr=0 and mem_addr holds the last driven value. The resulting SRAM read is discarded (rd_pend=0).
- Requesters must hold req/wr/addr/din until they see gnt; gnt is the handshake. Deasserting req without a grant is allowed and has no effect.
- Same-address write then read in consecutive grants returns the new data, since the SRAM write lands at the edge.
- Reset mid-operation: a pending read is dropped (no rvalid), and INIT restarts from address 0.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs a_gnt_cnt and b_gnt_cnt, 16 bits each, counting grants per requester.
  - Counters saturate at 16'hFFFF and are cleared by reset.
  - Adds output conflict_cnt, 16 bits, saturating, incremented in each RUN cycle where both req are high.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {INIT, RUN};
  - requester-id enum {REQ_A, REQ_B};
  - STAT_WIDTH=16 constant.
- Sub-module rr_arb2: two-input round-robin picker, combinational grant plus registered rr_last. It is the one natural split.
- The FSM, init counter and read-return pipeline stay in the top module.

Test Plan:
- Reset, then idle for DEPTH=16 cycles:
  - mem_wr=1 with addresses 0..15 and din=0;
  - init_done rises after cycle 16;
  - a_req held during INIT gets no a_gnt.
- After init, A writes addr 3 = 4'hA, then A reads addr 3 → a_gnt in both cycles; a_rvalid=1 with a_rdata=4'hA one cycle after the read grant; b_rvalid stays 0.
- Both requesters hold read requests (A addr 1, B addr 2) for 4 cycles → grants alternate A,B,A,B; rvalid alternates a/b one cycle later with the correct data.
- Read of addr 5 after init with no prior write → rdata=0, confirming the zero-fill.
- Read granted to B, then rst asserted in the next cycle → no b_rvalid; INIT restarts at address 0.
- With SRAM_ARB_STATS_EN defined, run scenario 3 → a_gnt_cnt=2, b_gnt_cnt=2, conflict_cnt=4.
